// File: rtl/imm_extender.sv
// rtl/imm_extender.sv - immediate extender: sign/zero/upper/word-offset widening with registered result
// Optional byte modes 5/6 are enabled by defining IMM_EXTENDER_BYTE_MODES_EN.
module imm_extender #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [2:0]       mode,
  input  logic [IN_W-1:0]  imm_in,
  output logic [OUT_W-1:0] ext_comb,
  output logic [OUT_W-1:0] ext_out,
  output logic             out_vld,
  output logic             mode_err
);

  localparam logic [2:0] MODE_SEXT     = 3'd0;
  localparam logic [2:0] MODE_ZEXT     = 3'd1;
  localparam logic [2:0] MODE_UPPER    = 3'd2;
  localparam logic [2:0] MODE_SEXT_SL2 = 3'd3;
  localparam logic [2:0] MODE_ZEXT_SL2 = 3'd4;
`ifdef IMM_EXTENDER_BYTE_MODES_EN
  localparam logic [2:0] MODE_SEXT_B   = 3'd5;
  localparam logic [2:0] MODE_ZEXT_B   = 3'd6;
`endif

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;
  logic [OUT_W-1:0] upper_val;
  logic             comb_err;

  assign sext_val  = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
  assign zext_val  = {{(OUT_W-IN_W){1'b0}}, imm_in};
  assign upper_val = {imm_in, {(OUT_W-IN_W){1'b0}}};

  // Unsupported codes still yield the sign-extended value so downstream sees a defined operand.
  always_comb begin
    ext_comb = sext_val;
    comb_err = 1'b0;
    case (mode)
      MODE_SEXT:     ext_comb = sext_val;
      MODE_ZEXT:     ext_comb = zext_val;
      MODE_UPPER:    ext_comb = upper_val;
      MODE_SEXT_SL2: ext_comb = sext_val << 2;
      MODE_ZEXT_SL2: ext_comb = zext_val << 2;
`ifdef IMM_EXTENDER_BYTE_MODES_EN
      MODE_SEXT_B:   ext_comb = {{(OUT_W-8){imm_in[7]}}, imm_in[7:0]};
      MODE_ZEXT_B:   ext_comb = {{(OUT_W-8){1'b0}}, imm_in[7:0]};
`endif
      default: begin
        ext_comb = sext_val;
        comb_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_out  <= '0;
      out_vld  <= 1'b0;
      mode_err <= 1'b0;
    end else if (in_vld) begin
      ext_out  <= ext_comb;
      out_vld  <= 1'b1;
      mode_err <= comb_err;
    end else begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extender.sv
// tb/tb_imm_extender.sv - scoreboard bench for imm_extender against an arithmetic reference model
module tb_imm_extender;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_vld = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [IN_W-1:0]  imm_in = '0;
  logic [OUT_W-1:0] ext_comb;
  logic [OUT_W-1:0] ext_out;
  logic             out_vld;
  logic             mode_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [OUT_W:0] exp_q[$];
  logic           exp_vld = 1'b0;
  logic           exp_rst = 1'b1;
  logic [OUT_W-1:0] last_ext = '0;
  logic             last_err = 1'b0;

  imm_extender #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .mode(mode), .imm_in(imm_in),
    .ext_comb(ext_comb), .ext_out(ext_out), .out_vld(out_vld), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // Reference: treat the immediate as a number, scale it, reduce modulo 2^OUT_W.
  function automatic logic [OUT_W:0] model(input int m, input int imm);
    longint s, z, b_s, b_z, r;
    logic   err;
    logic [63:0] rv;
    z   = longint'(imm);
    s   = (z >= 32768) ? z - 65536 : z;
    b_z = z % 256;
    b_s = (b_z >= 128) ? b_z - 256 : b_z;
    err = 1'b0;
    case (m)
      0: r = s;
      1: r = z;
      2: r = z * 65536;
      3: r = s * 4;
      4: r = z * 4;
`ifdef IMM_EXTENDER_BYTE_MODES_EN
      5: r = b_s;
      6: r = b_z;
`endif
      default: begin r = s; err = 1'b1; end
    endcase
    rv = r;
    return {err, rv[OUT_W-1:0]};
  endfunction

  task automatic check(input string name, input logic [OUT_W:0] act, input logic [OUT_W:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard push side: expectations follow what the DUT sampled at each edge.
  always @(posedge clk) begin
    exp_rst <= !rst_n;
    if (!rst_n) begin
      exp_vld <= 1'b0;
      exp_q.delete();
    end else if (in_vld) begin
      exp_q.push_back(model(int'(mode), int'(imm_in)));
      exp_vld <= 1'b1;
    end else begin
      exp_vld <= 1'b0;
    end
  end

  // Monitor: pops whenever the DUT presents a valid result; otherwise checks hold/reset.
  initial begin
    logic [OUT_W:0] e;
    forever begin
      @(negedge clk);
      if (exp_rst) begin
        check("reset_outputs", {mode_err, ext_out}, '0);
        check("reset_vld", {32'd0, out_vld}, '0);
        last_ext = '0;
        last_err = 1'b0;
      end else if (out_vld !== exp_vld) begin
        check("out_vld", {32'd0, out_vld}, {32'd0, exp_vld});
      end else if (out_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {mode_err, ext_out}, {1'b1, 32'hDEADBEEF} ^ {mode_err, ext_out} ^ {mode_err, ext_out} ^ 33'h1);
        end else begin
          e = exp_q.pop_front();
          check("ext_out", {mode_err, ext_out}, e);
          last_ext = e[OUT_W-1:0];
          last_err = e[OUT_W];
        end
      end else begin
        check("hold", {mode_err, ext_out}, {last_err, last_ext});
      end
    end
  end

  task automatic drive(input logic v, input int m, input int imm);
    logic [OUT_W:0] e;
    @(posedge clk);
    #1;
    in_vld = v;
    mode   = 3'(m);
    imm_in = 16'(imm);
    #1;
    e = model(m, imm);
    check("ext_comb", {1'b0, ext_comb}, {1'b0, e[OUT_W-1:0]});
  endtask

  initial begin
    // Reset held for two cycles with a request asserted.
    rst_n = 1'b0;
    in_vld = 1'b1;
    mode = 3'd0;
    imm_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(1, 0, 16'h007D);
    drive(1, 0, 16'h8000);
    drive(1, 1, 16'h8000);
    drive(1, 2, 16'h1234);
    drive(1, 3, 16'hFFFF);
    drive(1, 4, 16'hFFFF);
    drive(1, 3, 16'h0108);
    drive(1, 5, 16'h0085);
    drive(1, 7, 16'h0085);
    drive(1, 6, 16'h00F0);
    // Idle with undriven immediate: registered outputs must hold.
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    imm_in = 'x;
    mode   = 3'd2;
    repeat (3) @(posedge clk);

    // Back-to-back stream, then a mid-stream reset.
    for (int i = 0; i < 5; i++) drive(1, i, int'($urandom_range(0, 65535)));
    drive(0, 0, 0);
    drive(0, 1, 16'hAAAA);
    for (int i = 0; i < 3; i++) drive(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_vld = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
    drive(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", {1'b0, 32'(exp_q.size())}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
